// File: rtl/regfile_pkg.sv
// Shared defaults and types for the rv32i register file and its scoreboard.
package regfile_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;

    typedef logic [4:0]          reg_idx_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: flush > issue-set > writeback-clear.
// rd_busy masks a register being cleared by the current writeback.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned NRD  = 2,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    output logic [NREG-1:0]   busy_vec
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

    logic [NREG-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wr_en && wr_addr != ZERO_IDX) begin
                busy_d[wr_addr] = 1'b0;
            end
            // Applied after the clear so a new producer supersedes the retiring one.
            if (iss_en && iss_addr != ZERO_IDX) begin
                busy_d[iss_addr] = 1'b1;
            end
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_busy[k] = busy_q[rd_addr[k*AW +: AW]]
                         & ~(wr_en && wr_addr == rd_addr[k*AW +: AW]);
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-through read ports, hardwired x0 and busy-bit scoreboard.
// Define REGFILE_TRACE_EN to print committed writes and flushes in simulation.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned NRD  = 2,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic            wr_hit;

    assign wr_hit = wr_en && (wr_addr != ZERO_IDX);

    always_comb begin
        mem_d = mem_q;
        if (wr_hit) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NRD; k++) begin
            if (rd_addr[k*AW +: AW] == ZERO_IDX) begin
                rd_data[k*XLEN +: XLEN] = '0;
            end else if (wr_hit && wr_addr == rd_addr[k*AW +: AW]) begin
                rd_data[k*XLEN +: XLEN] = wr_data;
            end else begin
                rd_data[k*XLEN +: XLEN] = mem_q[rd_addr[k*AW +: AW]];
            end
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .flush    (flush),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .busy_vec (busy_vec)
    );

`ifdef REGFILE_TRACE_EN
    always @(posedge clk) begin
        if (rst) begin
            if (wr_hit) begin
                $display("x%0d <= %h", wr_addr, wr_data);
            end
            if (flush) begin
                $display("scoreboard flush");
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default XLEN=32, NREG=32, NRD=2).
module tb_regfile_sb;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic [NREG-1:0]     busy_vec;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    regfile_sb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        iss_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        rst      = 1'b0;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;

        #12;
        check("reset_rd_data", 64'(rd_data), 64'h0);
        check("reset_busy_vec", 64'(busy_vec), 64'h0);
        rst = 1'b1;
        step();

        // Reset contents and zero register
        for (int i = 0; i < 4; i++) begin
            set_rd(AW'(i), AW'(3 - i));
            #1;
            check($sformatf("reset_read_%0d", i), 64'(rd_data), 64'h0);
            check($sformatf("reset_rdbusy_%0d", i), 64'(rd_busy), 64'h0);
        end

        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF;
        set_rd(5'd0, 5'd0);
        #1;
        check("x0_no_bypass", 64'(rd_data), 64'h0);
        step();
        idle();
        #1;
        check("x0_after_write", 64'(rd_data), 64'h0);

        // Write-through bypass to a non-busy register
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678;
        set_rd(5'd5, 5'd6);
        #1;
        check("bypass_same_cycle", 64'(rd_data), {32'h0, 32'h1234_5678});
        step();
        idle();
        #1;
        check("bypass_after_edge", 64'(rd_data), {32'h0, 32'h1234_5678});
        check("wb_nonbusy_stays_clear", 64'(busy_vec), 64'h0);

        // Issue then writeback
        iss_en = 1'b1; iss_addr = 5'd7;
        set_rd(5'd5, 5'd7);
        #1;
        check("issue_not_yet_busy", 64'(rd_busy), 64'h0);
        step();
        idle();
        #1;
        check("issue_busy_vec", 64'(busy_vec), 64'h80);
        check("issue_rd_busy", 64'(rd_busy), 64'h2);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        #1;
        check("wb_rd_busy_masked", 64'(rd_busy), 64'h0);
        check("wb_bypass_data", 64'(rd_data[63:32]), 64'h77);
        check("wb_busy_vec_pending", 64'(busy_vec), 64'h80);
        step();
        idle();
        #1;
        check("wb_busy_cleared", 64'(busy_vec), 64'h0);

        // Set/clear collision: set wins, data still written
        iss_en = 1'b1; iss_addr = 5'd9;
        step();
        iss_en = 1'b1; iss_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5;
        step();
        idle();
        set_rd(5'd9, 5'd0);
        #1;
        check("collide_data", 64'(rd_data[31:0]), 64'hA5);
        check("collide_busy_vec", 64'(busy_vec), 64'h200);
        check("collide_rd_busy", 64'(rd_busy), 64'h1);

        // Flush beats issue; storage write still lands
        iss_en = 1'b1; iss_addr = 5'd3;
        step();
        iss_addr = 5'd4;
        step();
        idle();
        #1;
        check("preflush_busy_vec", 64'(busy_vec), 64'h218);
        flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd6;
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hAA;
        step();
        idle();
        set_rd(5'd6, 5'd10);
        #1;
        check("flush_busy_vec", 64'(busy_vec), 64'h0);
        check("flush_write_kept", 64'(rd_data), {32'hAA, 32'h0});

        // Issue and writeback to different registers in one cycle
        iss_en = 1'b1; iss_addr = 5'd12;
        step();
        iss_en = 1'b1; iss_addr = 5'd11;
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hC;
        step();
        idle();
        #1;
        check("indep_busy_vec", 64'(busy_vec), 64'h800);

        // Async reset between edges
        iss_en = 1'b1; iss_addr = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hFF;
        step();
        idle();
        set_rd(5'd4, 5'd5);
        #1;
        check("prereset_data", 64'(rd_data), {32'h1234_5678, 32'hFF});
        check("prereset_busy_vec", 64'(busy_vec), 64'h810);
        #1;
        rst = 1'b0;
        #1;
        check("async_reset_data", 64'(rd_data), 64'h0);
        check("async_reset_busy", 64'(busy_vec), 64'h0);
        #1;
        rst = 1'b1;
        step();
        check("post_reset_data", 64'(rd_data), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file for the rv32i pipeline, with an integrated busy-bit scoreboard. It serves NRD combinational read ports with same-cycle write-through bypass and a hardwired-zero register 0. Decode sets busy bits when an instruction issues with a destination; writeback clears them. Hazard logic in decode consumes rd_busy to stall. It replaces the fixed 32x32, 2-read-port file.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of registers (power of two, >=2)
NRD, 2, number of read ports (1..4)
AW, $clog2(NREG), register index width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
rd_addr  input  NRD*AW  read indices, port k at bits [k*AW +: AW]
rd_data  output  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN]
rd_busy  output  NRD  port k source has an outstanding producer
wr_en  input  1  writeback enable
wr_addr  input  AW  writeback index
wr_data  input  XLEN  writeback data
iss_en  input  1  issue of an instruction with a destination register
iss_addr  input  AW  destination index of the issuing instruction
flush  input  1  pipeline flush, clears all busy bits
busy_vec  output  NREG  raw scoreboard state, for debug

Behaviour:
- Reset (rst=0, asynchronous): all registers go to 0 and all busy bits go to 0. Combinational outputs then reflect that state: rd_data=0, rd_busy=0, busy_vec=0.
- Storage write: on posedge clk with wr_en=1 and wr_addr!=0, mem[wr_addr] <= wr_data. Writes to index 0 are discarded.
- Read: combinational, zero-latency.
  - rd_addr==0 returns 0.
  - If wr_en=1, wr_addr==rd_addr and wr_addr!=0, return wr_data (write-through bypass).
  - Otherwise return mem[rd_addr].
- Scoreboard next-state, in priority order:
  - flush=1: all busy bits <= 0, and iss_en is ignored that cycle. A storage write still occurs.
  - iss_en=1 and iss_addr!=0: busy[iss_addr] <= 1. Set wins over a same-cycle clear of the same index, because a new producer supersedes the old one.
  - wr_en=1 and wr_addr!=0: busy[wr_addr] <= 0.
  - Issue and writeback to different indices apply independently in the same cycle.
- busy[0] is constant 0.
- rd_busy[k] = busy[rd_addr_k] & ~(wr_en & wr_addr==rd_addr_k). A register cleared by the current writeback is not reported busy, matching the data bypass. rd_busy for index 0 is always 0.
- Writeback to a register that is not busy is legal. Data is written and the busy bit stays 0.
- Repeated issue to an already-busy register keeps it busy. There is no counting; exactly one outstanding producer per register is assumed by the pipeline.
- Reset asserted mid-operation clears everything immediately, independent of clk.

Optional Feature:
REGFILE_TRACE_EN
- Defined: on each committed write (wr_en=1, wr_addr!=0, rst=1) at posedge clk, simulation prints "x<idx> <= <hex data>". On each flush it prints "scoreboard flush".
- Undefined: no display statements are compiled. The block is fully synthesizable with no simulation side effects.

Decomposition:
- Package regfile_pkg holds:
  - XLEN_DEF=32 and NREG_DEF=32
  - typedef reg_idx_t (logic [4:0])
  - typedef xword_t (logic [XLEN_DEF-1:0])
  - constant ZERO_REG=0
- One sub-module, regfile_scoreboard: busy-bit array with set/clear/flush priority and the rd_busy bypass. The top holds the storage array and the read muxes.

Test Plan:
- Reset and zero register: rst=0 then release; read ports 1..NRD at indices 0..3 -> rd_data all 0. Write x0=32'hDEADBEEF, then read x0 -> 0.
- Write-through bypass: same cycle wr_en=1, wr_addr=5, wr_data=32'h1234_5678, rd_addr port0=5 -> rd_data0=32'h12345678 before the edge. After the edge, with wr_en=0, still 32'h12345678.
- Issue/writeback: iss_en=1, iss_addr=7 -> next cycle busy_vec[7]=1 and rd_busy=1 on port reading 7. Then wr_en=1, wr_addr=7 -> rd_busy=0 in the same cycle, busy_vec[7]=0 next cycle.
- Set/clear collision: busy[9]=1, then same cycle iss_en with iss_addr=9 and wr_en with wr_addr=9, data 32'hA5 -> mem[9]=32'hA5 and busy[9] stays 1.
- Flush priority: busy[3]=busy[4]=1, then flush=1 with iss_en=1, iss_addr=6 -> next cycle busy_vec=0.
- Async reset mid-stream: with busy[4]=1 and mem[4]=32'hFF, pulse rst=0 between clock edges -> rd_data=0 and busy_vec=0 immediately, without waiting for a clock edge.
